nixie_scan_ctrl: RTL
====================

// Module: nixie_scan_ctrl
// PURPOSE
//  Parametrised multiplexed 7-segment scan controller; next generation of the 4-digit BCD scanner.
//  Drives DIGITS digits with hex decode, per-digit decimal points and leading-zero blanking.
//  Adds anti-ghost dead time, 16-level PWM brightness and tear-free frame-synchronous data update.
//  Sits between numeric/status logic and the board digit/segment pins.
// PARAMETERS
//  DIGITS        4       digit count, 1..8
//  CNT_SCAN_MAX  50_000  sys_clk cycles per digit slot (1 ms at 50 MHz)
//  BLANK_CYC     500     dead-time cycles at slot start, < CNT_SCAN_MAX
//  CS_ACT        1'b0    active level of nixie_cs bits
//  SEG_ACT       1'b1    active level of nixie_seg bits (common cathode)
// PORTS
//  sys_clk     in   1         system clock
//  sys_rst     in   1         synchronous reset, active-high
//  data_hex    in   4*DIGITS  nibble k -> digit k, digit 0 = least significant
//  dp_in       in   DIGITS    decimal point per digit
//  data_vld    in   1         1-cycle strobe: capture data_hex/dp_in
//  lzb_en      in   1         leading-zero blanking enable
//  bright      in   4         brightness 0 (dimmest) .. 15 (full)
//  nixie_cs    out  DIGITS    digit select, one-hot at CS_ACT level
//  nixie_seg   out  8         segments {dp,g,f,e,d,c,b,a}
//  frame_done  out  1         1-cycle pulse at frame boundary
// BEHAVIOUR
//  - Reset (synchronous): cnt_slot=0, dig_idx=0, pending/display regs=0, bright_r=4'hF,
//    nixie_cs all inactive, nixie_seg all inactive, frame_done=0. Takes effect on next edge, incl. mid-slot.
//  - Counters: cnt_slot counts 0..CNT_SCAN_MAX-1 and wraps. dig_idx increments at the wrap.
//    dig_idx wraps DIGITS-1 -> 0 and asserts the boundary (bnd).
//  - Capture: data_vld=1 loads pending regs; last strobe in a frame wins.
//  - At bnd, display regs load from pending, or from data_hex/dp_in if data_vld=1 that same cycle.
//    bright_r <= bright at bnd only. No change becomes visible mid-frame.
//  - frame_done registered, high the cycle after bnd; new data visible from the next slot-0 on-window.
//  - on_len = ((CNT_SCAN_MAX-BLANK_CYC)*(bright_r+1))>>4, computed once per frame, registered.
//  - Digit driven iff BLANK_CYC <= cnt_slot < BLANK_CYC+on_len; otherwise cs and seg are all inactive.
//  - Outputs registered: pins reflect counter state of the previous cycle.
//    cs[0] first asserts BLANK_CYC+1 edges after reset release.
//  - Decode: nibble 0..F -> hex glyph; dp bit7 = dp of displayed digit; polarity applied last.
//  - LZB: with lzb_en, digit k>0 blanked when nibble k and all higher nibbles are 0.
//    A blanked digit keeps its cs asserted, its segments a..g inactive, and its dp shown.
//    Digit 0 is never blanked.
//  - Invariant: at most one nixie_cs bit at CS_ACT in any cycle.
// STRUCTURE
//  - Package nixie_pkg: SEG_HEX[0:15] glyph table (active-high, e.g. 0->8'h3F, A->8'h77, F->8'h71),
//    SEG_BLANK=8'h00, clog2 helper.
//  - Sub-module nixie_seg7_dec: combinational nibble+dp+blank -> 8-bit active-high segments.
//  - Top holds counters, pending/display regs, PWM compare, LZB mask, output regs and elaboration checks.
// TESTING (DIGITS=4, CNT_SCAN_MAX=20, BLANK_CYC=4, CS_ACT=0, SEG_ACT=1)
//  1. sys_rst high 3 cycles -> nixie_cs=4'b1111, nixie_seg=8'h00, frame_done=0 throughout.
//  2. data_hex=16'h12AF, data_vld 1 cycle, bright=15 -> after frame_done, slots show seg 71,77,5B,06
//     on cs 1110,1101,1011,0111; each cs low 16 of 20 cycles.
//  3. vld 16'h0000 then vld 16'h1234 in one frame -> display unchanged until bnd, then shows 1234;
//     0000 never appears.
//  4. lzb_en=1, data 16'h0050 -> digits 3,2 seg 00 with cs active, digit1 6D, digit0 3F.
//     data 16'h0000 -> only digit0 shows 3F.
//  5. bright=3 -> on_len=4; each cs low exactly 4 cycles per slot, starting at cnt_slot=4.
//     A bright change mid-frame takes effect next frame.
//  6. sys_rst pulsed mid-slot of digit 2 -> next edge all outputs inactive, regs cleared;
//     scan restarts at digit 0.

Source files
------------

// File: rtl/nixie_pkg.sv
// -----------------------------------------------------------------------------
// nixie_pkg
//   Shared constants for the multiplexed 7-segment scan controller.
//   SEG_HEX   : active-high hex glyph table, bit order {dp,g,f,e,d,c,b,a},
//               dp bit always 0 here (dp is merged in by the decoder).
//   SEG_BLANK : active-high pattern for a dark digit.
//   clog2     : width helper, never returns less than 1 bit.
// -----------------------------------------------------------------------------
package nixie_pkg;

   localparam logic [7:0] SEG_HEX [0:15] = '{
      8'h3F, 8'h06, 8'h5B, 8'h4F,   // 0 1 2 3
      8'h66, 8'h6D, 8'h7D, 8'h07,   // 4 5 6 7
      8'h7F, 8'h6F, 8'h77, 8'h7C,   // 8 9 A b
      8'h39, 8'h5E, 8'h79, 8'h71    // C d E F
   };

   localparam logic [7:0] SEG_BLANK = 8'h00;

   // Bits needed to hold values 0..value-1; at least 1 so vectors stay legal.
   function automatic int clog2(input int value);
      int bits;
      bits = 0;
      for (int v = value - 1; v > 0; v = v >> 1) begin
         bits++;
      end
      return (bits < 1) ? 1 : bits;
   endfunction

endpackage

// File: rtl/nixie_seg7_dec.sv
// -----------------------------------------------------------------------------
// nixie_seg7_dec
//   Combinational hex digit decoder, active-high output.
//   Ports:
//     nibble in  4  hex value to show
//     dp     in  1  decimal point of this digit
//     blank  in  1  force segments a..g dark (dp is still shown)
//     seg    out 8  {dp,g,f,e,d,c,b,a}, active-high
// -----------------------------------------------------------------------------
module nixie_seg7_dec (
   input  logic [3:0] nibble,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg
);
   import nixie_pkg::*;

   // NOTE: every signal written in always_comb gets a value before any branch,
   // otherwise a path that skips the assignment infers a latch.
   always_comb begin
      seg = SEG_HEX[nibble];
      if (blank) begin
         seg[6:0] = SEG_BLANK[6:0];
      end
      seg[7] = dp;
   end

endmodule

// File: rtl/nixie_scan_ctrl.sv
// -----------------------------------------------------------------------------
// nixie_scan_ctrl
//   Multiplexed 7-segment scan controller: hex decode, per-digit decimal point,
//   leading-zero blanking, anti-ghost dead time at each slot start, 16-level
//   PWM brightness and frame-synchronous (tear-free) data/brightness update.
//   Ports:
//     sys_clk    in   1         system clock
//     sys_rst    in   1         synchronous reset, active-high
//     data_hex   in   4*DIGITS  nibble k drives digit k (digit 0 = LSD)
//     dp_in      in   DIGITS    decimal point per digit
//     data_vld   in   1         capture strobe for data_hex/dp_in
//     lzb_en     in   1         leading-zero blanking enable
//     bright     in   4         brightness, 0 dimmest .. 15 full
//     nixie_cs   out  DIGITS    digit select, one-hot at CS_ACT
//     nixie_seg  out  8         segments {dp,g,f,e,d,c,b,a} at SEG_ACT
//     frame_done out  1         one-cycle pulse after each frame boundary
// -----------------------------------------------------------------------------
module nixie_scan_ctrl #(
   parameter int   DIGITS       = 4,
   parameter int   CNT_SCAN_MAX = 50_000,
   parameter int   BLANK_CYC    = 500,
   parameter logic CS_ACT       = 1'b0,
   parameter logic SEG_ACT      = 1'b1
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [4*DIGITS-1:0]   data_hex,
   input  logic [DIGITS-1:0]     dp_in,
   input  logic                  data_vld,
   input  logic                  lzb_en,
   input  logic [3:0]            bright,
   output logic [DIGITS-1:0]     nixie_cs,
   output logic [7:0]            nixie_seg,
   output logic                  frame_done
);
   import nixie_pkg::*;

   localparam int CNT_W = clog2(CNT_SCAN_MAX);
   localparam int DIG_W = clog2(DIGITS);
   // Product width for span*(bright+1), bright+1 <= 16.
   localparam int PW    = CNT_W + 5;
   // Compare width with headroom so BLANK_CYC+on_len cannot overflow.
   localparam int CW    = CNT_W + 2;

   localparam logic [PW-1:0]    ON_SPAN   = PW'(CNT_SCAN_MAX - BLANK_CYC);
   localparam logic [CW-1:0]    BLANK_X   = CW'(BLANK_CYC);
   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CNT_SCAN_MAX - 1);
   localparam logic [DIG_W-1:0] DIG_LAST  = DIG_W'(DIGITS - 1);

   // Elaboration checks on the parameter set.
   if (DIGITS < 1 || DIGITS > 8) begin : g_chk_digits
      $error("nixie_scan_ctrl: DIGITS must be 1..8");
   end
   if (CNT_SCAN_MAX < 2) begin : g_chk_scan
      $error("nixie_scan_ctrl: CNT_SCAN_MAX must be at least 2");
   end
   if (BLANK_CYC < 0 || BLANK_CYC >= CNT_SCAN_MAX) begin : g_chk_blank
      $error("nixie_scan_ctrl: BLANK_CYC must be below CNT_SCAN_MAX");
   end

   logic [CNT_W-1:0]    cnt_slot;
   logic [DIG_W-1:0]    dig_idx;
   logic                slot_end;
   logic                bnd;

   logic [4*DIGITS-1:0] pend_hex;
   logic [DIGITS-1:0]   pend_dp;
   logic [4*DIGITS-1:0] disp_hex;
   logic [DIGITS-1:0]   disp_dp;
   logic [3:0]          bright_r;

   logic [PW-1:0]       on_prod;
   logic [CW-1:0]       on_len;
   logic [CW-1:0]       cnt_x;
   logic                drive;

   logic [DIGITS-1:0]   blank_mask;
   logic                lead_zero;
   logic [DIGITS-1:0]   cs_onehot;
   logic [3:0]          cur_nib;
   logic                cur_dp;
   logic                cur_blank;
   logic [7:0]          seg_ah;

   // ---------------------------------------------------------------- counters
   assign slot_end = (cnt_slot == CNT_LAST);
   assign bnd      = slot_end && (dig_idx == DIG_LAST);

   // NOTE: clocked state uses non-blocking assignments so every register sees
   // the pre-edge value of its neighbours, independent of statement order.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         cnt_slot <= '0;
         dig_idx  <= '0;
      end else if (slot_end) begin
         cnt_slot <= '0;
         dig_idx  <= bnd ? '0 : dig_idx + DIG_W'(1);
      end else begin
         cnt_slot <= cnt_slot + CNT_W'(1);
      end
   end

   // ------------------------------------------- pending / display registers
   // Pending regs follow every strobe; display regs only move at the frame
   // boundary, taking a strobe that coincides with the boundary directly.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         pend_hex <= '0;
         pend_dp  <= '0;
         disp_hex <= '0;
         disp_dp  <= '0;
         bright_r <= 4'hF;
      end else begin
         if (data_vld) begin
            pend_hex <= data_hex;
            pend_dp  <= dp_in;
         end
         if (bnd) begin
            disp_hex <= data_vld ? data_hex : pend_hex;
            disp_dp  <= data_vld ? dp_in    : pend_dp;
            bright_r <= bright;
         end
      end
   end

   // ------------------------------------------------------------ PWM window
   // bright_r is frame-stable, so on_len is constant over a frame.
   assign on_prod = ON_SPAN * (PW'(bright_r) + PW'(1));
   assign on_len  = CW'(on_prod >> 4);
   assign cnt_x   = CW'(cnt_slot);
   assign drive   = (cnt_x >= BLANK_X) && (cnt_x < BLANK_X + on_len);

   // --------------------------------------------------- leading-zero blanking
   // Walk from the top digit down; a digit is blanked while everything from it
   // upward is zero. Digit 0 is outside the loop and never blanked.
   always_comb begin
      lead_zero  = 1'b1;
      blank_mask = '0;
      for (int k = DIGITS - 1; k > 0; k--) begin
         lead_zero     = lead_zero & (disp_hex[4*k +: 4] == 4'h0);
         blank_mask[k] = lzb_en & lead_zero;
      end
   end

   // ----------------------------------------------------- current-digit mux
   always_comb begin
      cur_nib   = 4'h0;
      cur_dp    = 1'b0;
      cur_blank = 1'b0;
      cs_onehot = '0;
      for (int k = 0; k < DIGITS; k++) begin
         if (dig_idx == DIG_W'(k)) begin
            cur_nib      = disp_hex[4*k +: 4];
            cur_dp       = disp_dp[k];
            cur_blank    = blank_mask[k];
            cs_onehot[k] = 1'b1;
         end
      end
   end

   nixie_seg7_dec u_dec (
      .nibble (cur_nib),
      .dp     (cur_dp),
      .blank  (cur_blank),
      .seg    (seg_ah)
   );

   // -------------------------------------------------------- output registers
   // Polarity is applied here, after decode; outside the on-window both buses
   // sit at their inactive level so neighbouring digits never ghost.
   always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
         nixie_cs   <= {DIGITS{~CS_ACT}};
         nixie_seg  <= {8{~SEG_ACT}};
         frame_done <= 1'b0;
      end else begin
         frame_done <= bnd;
         if (drive) begin
            nixie_cs  <= CS_ACT  ? cs_onehot : ~cs_onehot;
            nixie_seg <= SEG_ACT ? seg_ah    : ~seg_ah;
         end else begin
            nixie_cs  <= {DIGITS{~CS_ACT}};
            nixie_seg <= {8{~SEG_ACT}};
         end
      end
   end

endmodule
